// File: rtl/mult_error_sweep.sv
// Exhaustive error sweep around a W-bit approximate multiplier.
// Accumulates mismatch count, max/summed abs error and mean relative error.
module mult_error_sweep #(
  parameter int W    = 4,
  parameter int FRAC = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [W-1:0]        op_a,
  output logic [W-1:0]        op_b,
  input  logic [2*W-1:0]      approx_in,
  output logic [2*W:0]        err_count,
  output logic [2*W-1:0]      max_abs_err,
  output logic [4*W-1:0]      sum_abs_err,
  output logic [2*W+FRAC-1:0] mre
);

  localparam int PW = 2 * W;
  localparam int QW = 2 * W + FRAC;
  localparam int RW = 4 * W + FRAC;
  localparam int CW = $clog2(QW + 1);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    CALC,
    DIV,
    NEXT,
    FIN
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   idx_q;
  logic [PW-1:0]   approx_q;
  logic [PW-1:0]   div_q;
  logic [PW-1:0]   rem_q;
  logic [QW-1:0]   dvd_q;
  logic [CW-1:0]   cnt_q;
  logic [PW:0]     err_q;
  logic [PW-1:0]   max_q;
  logic [4*W-1:0]  sum_q;
  logic [RW-1:0]   rel_q;
  logic            busy_q;
  logic            done_q;

  logic [PW-1:0]   exact;
  logic [PW-1:0]   abs_err;
  logic [PW:0]     rem_sh;
  logic [PW:0]     rem_d;
  logic            q_bit;

  assign exact = {{W{1'b0}}, idx_q[PW-1:W]} *
                 {{W{1'b0}}, idx_q[W-1:0]};

  assign abs_err = (approx_q >= exact) ? approx_q - exact
                                       : exact - approx_q;

  // Restoring step: dividend bits stream out of dvd_q MSB,
  // quotient bits stream into its LSB.
  assign rem_sh = {rem_q, dvd_q[QW-1]};
  assign q_bit  = rem_sh >= {1'b0, div_q};
  assign rem_d  = q_bit ? rem_sh - {1'b0, div_q} : rem_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      approx_q <= '0;
      div_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      cnt_q    <= '0;
      err_q    <= '0;
      max_q    <= '0;
      sum_q    <= '0;
      rel_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= DRIVE;
            busy_q  <= 1'b1;
            idx_q   <= '0;
            err_q   <= '0;
            max_q   <= '0;
            sum_q   <= '0;
            rel_q   <= '0;
          end
        end
        DRIVE: begin
          approx_q <= approx_in;
          state_q  <= CALC;
        end
        CALC: begin
          if (abs_err != '0) begin
            err_q <= err_q + (PW+1)'(1);
            sum_q <= sum_q + (4*W)'(abs_err);
            if (abs_err > max_q)
              max_q <= abs_err;
          end
          rem_q <= '0;
          cnt_q <= '0;
          div_q <= exact;
          if (abs_err != '0 && exact != '0) begin
            dvd_q   <= {abs_err, {FRAC{1'b0}}};
            state_q <= DIV;
          end else begin
            dvd_q   <= '0;
            state_q <= NEXT;
          end
        end
        DIV: begin
          dvd_q <= {dvd_q[QW-2:0], q_bit};
          rem_q <= rem_d[PW-1:0];
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(QW - 1))
            state_q <= NEXT;
        end
        NEXT: begin
          rel_q <= rel_q + RW'(dvd_q);
          if (&idx_q) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end else begin
            idx_q   <= idx_q + PW'(1);
            state_q <= DRIVE;
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign op_a        = idx_q[PW-1:W];
  assign op_b        = idx_q[W-1:0];
  assign err_count   = err_q;
  assign max_abs_err = max_q;
  assign sum_abs_err = sum_q;
  assign mre         = rel_q[RW-1:PW];

endmodule

// File: tb/tb_mult_error_sweep.sv
// Bench for mult_error_sweep: stub multipliers, result table,
// start-pestering and mid-sweep reset sequences.
module tb_mult_error_sweep;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done;
  logic [3:0]  op_a, op_b;
  logic [7:0]  approx_in;
  logic [8:0]  err_count;
  logic [7:0]  max_abs_err;
  logic [15:0] sum_abs_err;
  logic [15:0] mre;
  int          mode = 0;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int mode;
    bit pester;
    int err;
    int mx;
    int sum;
    int mre;
    int edges;
  } vec_t;

  vec_t tbl[7];
  vec_t sb[$];

  always #5 clk = ~clk;

  mult_error_sweep dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .busy(busy),
    .done(done),
    .op_a(op_a),
    .op_b(op_b),
    .approx_in(approx_in),
    .err_count(err_count),
    .max_abs_err(max_abs_err),
    .sum_abs_err(sum_abs_err),
    .mre(mre)
  );

  always_comb begin
    approx_in = 8'(op_a) * 8'(op_b);
    case (mode)
      1: approx_in = 8'd0;
      2: if (op_a == 4'd15 && op_b == 4'd15)
           approx_in = 8'd0;
      3: approx_in = 8'(op_a) * 8'(op_b) + 8'd1;
      default: ;
    endcase
  end

  task automatic check(input string nm,
                       input longint act,
                       input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " op_a"}, op_a, 0);
    check({tag, " op_b"}, op_b, 0);
    check({tag, " err_count"}, err_count, 0);
    check({tag, " max_abs_err"}, max_abs_err, 0);
    check({tag, " sum_abs_err"}, sum_abs_err, 0);
    check({tag, " mre"}, mre, 0);
  endtask

  task automatic run(input int m, input bit pester);
    vec_t e;
    int   edges;
    mode = m;
    edges = -1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy after start", busy, 1);
    for (int n = 1; n <= 6000; n++) begin
      @(posedge clk);
      #1;
      start = pester && (n % 97 == 0);
      if (done) begin
        edges = n;
        break;
      end
    end
    if (edges < 0) begin
      check("done timeout", 0, 1);
      start = 1'b0;
      return;
    end
    e = sb.pop_front();
    check("done edge", edges, e.edges);
    check("err_count", err_count, e.err);
    check("max_abs_err", max_abs_err, e.mx);
    check("sum_abs_err", sum_abs_err, e.sum);
    check("mre", mre, e.mre);
    check("busy in done", busy, 1);
    check("last op_a", op_a, 15);
    check("last op_b", op_b, 15);
    start = pester;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy falls", busy, 0);
    check("done pulse", done, 0);
    @(posedge clk);
    #1;
    check("no restart", busy, 0);
    check("hold err_count", err_count, e.err);
    check("hold mre", mre, e.mre);
  endtask

  initial begin
    int gold;
    gold = 0;
    for (int a = 1; a < 16; a++)
      for (int b = 1; b < 16; b++)
        gold += 256 / (a * b);

    tbl[0] = '{0, 1'b0, 0,   0,   0,     0,        768};
    tbl[1] = '{1, 1'b0, 225, 225, 14400, 225,      4368};
    tbl[2] = '{2, 1'b0, 1,   225, 225,   1,        784};
    tbl[3] = '{3, 1'b0, 256, 1,   256,   gold / 256, 4368};
    tbl[4] = '{1, 1'b1, 225, 225, 14400, 225,      4368};
    tbl[5] = '{1, 1'b0, 225, 225, 14400, 225,      4368};
    tbl[6] = '{2, 1'b1, 1,   225, 225,   1,        784};

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      sb.push_back(tbl[i]);
      run(tbl[i].mode, tbl[i].pester);
    end

    mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    check("mid-sweep busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_zero("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(tbl[1]);
    run(1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
